// File: rtl/serial_pkg.sv
// Shared types and frame constants for the 7-bit serial transmitter.
package serial_pkg;

  localparam int DATA_BITS  = 7;
  localparam int FRAME_BITS = 10;
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Line level for a frame position; position 0 is the start bit.
  function automatic logic frame_level(input logic [DATA_BITS-1:0] data,
                                       input logic parity,
                                       input logic [3:0] pos);
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, parity, data, 1'b0};
    return frame[pos];
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period timer: pulses tick_o on the last cycle of each CLKS_PER_BIT-cycle bit.
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: held at zero while restarting, wraps at the bit boundary.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q == CNT_MAX) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = !restart_i && (count_q == CNT_MAX);

endmodule

// File: rtl/serial_tx7.sv
// Serial transmitter: start bit, 7 data bits LSB first, parity bit, stop bit.
module serial_tx7
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 parity_in,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy
);

  tx_state_e            state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_q, tx_out_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 tick_s;
  logic                 restart_s;
  logic [2:0]           idx_inc_s;

  // The timer idles at zero so the start bit gets a full period from acceptance.
  assign restart_s = (state_q == IDLE);
  assign idx_inc_s = bit_idx_q + 3'd1;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart_i(restart_s),
    .tick_o   (tick_s)
  );

  // Next-state and next line level; tx_out_d is the level of the bit about to start.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    parity_d  = parity_q;
    tx_out_d  = tx_out_q;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d   = START;
          data_d    = data_in;
          parity_d  = parity_in;
          bit_idx_d = 3'd0;
          tx_out_d  = 1'b0;
        end else begin
          tx_out_d  = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_out_d  = data_q[0];
        end else begin
          tx_out_d  = 1'b0;
        end
      end
      DATA: begin
        if (tick_s && (bit_idx_q == LAST_IDX)) begin
          state_d   = PARITY;
          tx_out_d  = parity_q;
        end else if (tick_s) begin
          bit_idx_d = idx_inc_s;
          tx_out_d  = data_q[idx_inc_s];
        end else begin
          tx_out_d  = data_q[bit_idx_q];
        end
      end
      PARITY: begin
        if (tick_s) begin
          state_d  = STOP;
          tx_out_d = 1'b1;
        end else begin
          tx_out_d = parity_q;
        end
      end
      STOP: begin
        if (tick_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
        tx_out_d = 1'b1;
      end
      default: begin
        state_d   = IDLE;
        bit_idx_d = 3'd0;
        tx_out_d  = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State, captured character and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= 3'd0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx7.sv
// Directed bench for serial_tx7 with CLKS_PER_BIT=4; outputs sampled on falling edges.
module tb_serial_tx7;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] data_in = 7'h00;
  logic       parity_in = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_out;
  logic       busy;

  int n_total = 0;
  int n_bad   = 0;

  serial_tx7 #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .parity_in(parity_in),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mk_frame(input logic [6:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Called on a falling edge; returns on the falling edge of the first start-bit cycle.
  task automatic start_req(input logic [6:0] d, input logic p, input bit hold);
    data_in   = d;
    parity_in = p;
    tx_valid  = 1'b1;
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
  endtask

  // Checks 10*CPB cycles of line, busy and ready, then the idle cycle after the frame.
  task automatic check_frame(input logic [9:0] f, input string tag, input bit inject);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        check_eq($sformatf("%s bit%0d cyc%0d tx_out", tag, i, c), 32'(tx_out), 32'(f[i]));
        check_eq($sformatf("%s bit%0d cyc%0d busy", tag, i, c), 32'(busy), 32'd1);
        check_eq($sformatf("%s bit%0d cyc%0d ready", tag, i, c), 32'(tx_ready), 32'd0);
        if (inject && i == 3 && c == 0) begin
          tx_valid  = 1'b1;
          data_in   = 7'h7F;
          parity_in = 1'b1;
        end
        if (inject && i == 3 && c == 2) tx_valid = 1'b0;
        @(negedge clk);
      end
    end
    check_eq({tag, " after tx_out"}, 32'(tx_out), 32'd1);
    check_eq({tag, " after busy"}, 32'(busy), 32'd0);
    check_eq({tag, " after ready"}, 32'(tx_ready), 32'd1);
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s idle%0d tx_out", tag, k), 32'(tx_out), 32'd1);
      check_eq($sformatf("%s idle%0d busy", tag, k), 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #12;
    check_eq("rst tx_out", 32'(tx_out), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, accepted on the first edge after reset release; hand-written line image.
    start_req(7'h41, 1'b0, 1'b0);
    check_frame(10'b10_1000_0010, "basic41", 1'b0);
    check_idle("basic41", 3);

    // Odd-weight character with parity 1.
    @(negedge clk);
    start_req(7'h07, 1'b1, 1'b0);
    check_frame(mk_frame(7'h07, 1'b1), "odd07", 1'b0);

    // Back-to-back with tx_valid held high.
    @(negedge clk);
    start_req(7'h55, 1'b0, 1'b1);
    data_in   = 7'h2A;
    parity_in = 1'b1;
    check_frame(mk_frame(7'h55, 1'b0), "b2b55", 1'b0);
    @(negedge clk);
    tx_valid = 1'b0;
    check_frame(mk_frame(7'h2A, 1'b1), "b2b2A", 1'b0);

    // Request during frame bit 3 must be dropped.
    @(negedge clk);
    start_req(7'h12, 1'b0, 1'b0);
    check_frame(mk_frame(7'h12, 1'b0), "ignore12", 1'b1);
    check_idle("ignore12", 8);

    // Input change one cycle after acceptance must not alter the frame.
    @(negedge clk);
    start_req(7'h3C, 1'b0, 1'b0);
    data_in   = 7'h00;
    parity_in = 1'b1;
    check_frame(mk_frame(7'h3C, 1'b0), "hold3C", 1'b0);

    // Asynchronous reset in the middle of the data bits.
    @(negedge clk);
    start_req(7'h00, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check_eq("midrst pre tx_out", 32'(tx_out), 32'd0);
    check_eq("midrst pre busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst tx_out", 32'(tx_out), 32'd1);
    check_eq("midrst busy", 32'(busy), 32'd0);
    check_eq("midrst ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst", 12);

    // Transmitter still works after the aborted frame.
    @(negedge clk);
    start_req(7'h5A, 1'b0, 1'b0);
    check_frame(mk_frame(7'h5A, 1'b0), "post5A", 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_tx7.md
SERIAL_TX7 -- requirements
Module: serial_tx7

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 data_in  input  7  character to send; comes from the upstream source.
REQ-005 parity_in  input  1  parity bit for data_in; driven by the upstream parity generator (XOR of the data bits).
REQ-006 tx_valid  input  1  data_in/parity_in valid; request to send one frame.
REQ-007 tx_ready  output  1  block can accept a frame this cycle.
REQ-008 tx_out  output  1  serial line; idle level high.
REQ-009 busy  output  1  frame in progress (any state other than IDLE).

Function
REQ-010 Frame, in line order: start bit (0), data_in[0]..data_in[6] LSB first, parity bit, stop bit (1); 10 bits total.
REQ-011 Handshake: a frame is accepted on a rising edge where tx_valid=1 and tx_ready=1; data_in and parity_in are captured into an internal register on that edge.
REQ-012 tx_ready=1 only in IDLE; tx_valid while tx_ready=0 is ignored (not queued).
REQ-013 Input changes after acceptance do not affect the frame in flight.
REQ-014 States: IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on acceptance; START -> DATA, DATA -> PARITY after bit index 6, PARITY -> STOP, STOP -> IDLE; each transition occurs at the end of its bit period.
REQ-016 Each bit period lasts exactly CLKS_PER_BIT cycles, counted by a bit-timer that reloads at every bit boundary.
REQ-017 Latency: tx_out drives the start bit (0) from the first cycle after the accepting edge.
REQ-018 Frame duration is exactly 10*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
REQ-019 tx_out is registered (no combinational path from inputs); tx_out=1 in IDLE and STOP.
REQ-020 Back-to-back frames: tx_ready rises in the cycle after the last stop-bit cycle; if tx_valid is held high, the next start bit follows exactly one idle-high cycle later.
REQ-021 The bit index is 3 bits and counts 0..6; it never wraps to 7 during DATA.
REQ-022 busy=1 from the first start-bit cycle through the last stop-bit cycle inclusive.

Reset
REQ-023 On rst_n=0, immediately and asynchronously: state=IDLE, tx_out=1, tx_ready=1, busy=0, bit timer=0, bit index=0, captured data=0.
REQ-024 Reset mid-frame aborts the frame; no partial bits follow after reset releases.
REQ-025 The first acceptance is possible on the first rising edge after rst_n deasserts.

Structure
REQ-026 Shared package serial_pkg holds the state enum (IDLE, START, DATA, PARITY, STOP), DATA_BITS=7 and FRAME_BITS=10.
REQ-027 One sub-module, baud_tick, holds the CLKS_PER_BIT bit-timer, sized $clog2(CLKS_PER_BIT).
REQ-028 baud_tick provides a one-cycle end-of-bit pulse and a synchronous restart input.
REQ-029 Total RTL 120-400 lines; no latches; the FSM has a single always_ff plus next-state logic.

Verification
REQ-030 Basic frame (CLKS_PER_BIT=4): data_in=7'h41, parity_in=0, one-cycle tx_valid -> tx_out sequence is 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles; busy high for 40 cycles.
REQ-031 Odd-weight character: data_in=7'h07, parity_in=1 -> parity bit period shows tx_out=1; all data bits are checked LSB first.
REQ-032 Back-to-back: tx_valid held high with 7'h55 then 7'h2A -> two frames separated by exactly one idle-high cycle; tx_ready pulses high for one cycle between them.
REQ-033 Ignored request: tx_valid asserted with 7'h7F during bit 3 of a frame -> in-flight frame is unchanged and no second frame is sent.
REQ-034 Reset mid-frame: rst_n=0 during the DATA state -> tx_out=1 and busy=0 in the same cycle; line stays idle after release until the next tx_valid.
REQ-035 Input hold: data_in changed to 7'h00 one cycle after acceptance of 7'h3C -> the transmitted bits match 7'h3C.
